// File: rtl/rv32_rf_pkg.sv
// -----------------------------------------------------------------------------
// rv32_rf_pkg
// Shared constants and types for the register-file writeback path.
//   DATA_W   : register data width
//   ADDR_W   : register index width (32 registers, x0 hardwired to zero)
//   X0_IDX   : index of the hardwired-zero register
//   req_id_e : requester identity driven on grant_id (REQ_EXE / REQ_LD)
//   ptr_state_e : round-robin pointer, records the last accepted requester
// -----------------------------------------------------------------------------
package rv32_rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] X0_IDX = 5'd0;

  typedef enum logic {
    REQ_EXE = 1'b0,
    REQ_LD  = 1'b1
  } req_id_e;

  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } ptr_state_e;

endpackage

// File: rtl/rf_rr_pick.sv
// -----------------------------------------------------------------------------
// rf_rr_pick
// Combinational grant decision between the execute (0) and load (1) writeback
// requesters.
//   v0, v1 : request valids
//   ptr    : last accepted requester; on a conflict the other one wins
//   grant  : one-hot grant, bit 0 = requester 0, bit 1 = requester 1
// -----------------------------------------------------------------------------
module rf_rr_pick
  import rv32_rf_pkg::*;
(
  input  logic       v0,
  input  logic       v1,
  input  ptr_state_e ptr,
  output logic [1:0] grant
);

  // One-hot grant from the two valids and the pointer
  always_comb begin
    grant = 2'b00;
    case ({v1, v0})
      2'b01: grant = 2'b01;
      2'b10: grant = 2'b10;
      2'b11: begin
        if (ptr == LAST1) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
// Arbitrates two writeback sources onto the single register-file write port.
// A lone requester is accepted in the same cycle; on a conflict the grant
// alternates (round robin). The accepted write is registered and appears on
// the write port one cycle after the accept. Writes to x0 are consumed but
// never raise rf_load.
//
// Build option: define RF_ARB_LOAD_PRIO_EN to give the load requester (1)
// fixed priority on conflicts; the round-robin pointer is then not built.
//
// Ports:
//   clk, res                  : clock, asynchronous active-low reset
//   req0_valid/ready/addr/data: execute-stage writeback handshake
//   req1_valid/ready/addr/data: load-return writeback handshake
//   rf_load, rf_addr, rf_data : register-file write port (registered)
//   grant_id                  : requester that produced the current write
//   conflict_cnt              : saturating count of cycles with both valid
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int DATA_W = rv32_rf_pkg::DATA_W,
  parameter int ADDR_W = rv32_rf_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_load,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              grant_id,
  output logic [CNT_W-1:0]  conflict_cnt
);

  import rv32_rf_pkg::*;

  logic [1:0]        grant_s;
  logic              accept0_s;
  logic              accept1_s;
  logic              accept_s;
  logic              both_s;
  ptr_state_e        ptr_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_data_s;
  logic              win_id_s;

  logic              rf_load_r;
  logic [ADDR_W-1:0] rf_addr_r;
  logic [DATA_W-1:0] rf_data_r;
  logic              grant_id_r;
  logic [CNT_W-1:0]  conflict_cnt_r;

  rf_rr_pick u_pick (
    .v0    (req0_valid),
    .v1    (req1_valid),
    .ptr   (ptr_s),
    .grant (grant_s)
  );

  // Readys are gated by reset so nothing can be consumed while res is low
  assign req0_ready = grant_s[0] & res;
  assign req1_ready = grant_s[1] & res;

  assign accept0_s = req0_valid & req0_ready;
  assign accept1_s = req1_valid & req1_ready;
  assign accept_s  = accept0_s | accept1_s;
  assign both_s    = req0_valid & req1_valid;

`ifdef RF_ARB_LOAD_PRIO_EN
  // Fixed pointer: a constant LAST0 makes requester 1 win every conflict
  always_comb begin
    ptr_s = LAST0;
  end
`else
  ptr_state_e ptr_r;
  ptr_state_e ptr_next_s;

  // Pointer state register; after reset requester 0 wins the first conflict
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ptr_r <= LAST1;
    end else begin
      ptr_r <= ptr_next_s;
    end
  end

  // Pointer next state: follow the accepted requester, hold when idle
  always_comb begin
    ptr_next_s = ptr_r;
    case (ptr_r)
      LAST0: begin
        if (accept1_s) begin
          ptr_next_s = LAST1;
        end else begin
          ptr_next_s = LAST0;
        end
      end
      LAST1: begin
        if (accept0_s) begin
          ptr_next_s = LAST0;
        end else begin
          ptr_next_s = LAST1;
        end
      end
      default: ptr_next_s = LAST1;
    endcase
  end

  // Pointer output decode presented to the grant picker
  always_comb begin
    ptr_s = LAST1;
    case (ptr_r)
      LAST0:   ptr_s = LAST0;
      LAST1:   ptr_s = LAST1;
      default: ptr_s = LAST1;
    endcase
  end
`endif

  // Select the accepted request's payload
  always_comb begin
    win_addr_s = req0_addr;
    win_data_s = req0_data;
    win_id_s   = REQ_EXE;
    if (accept1_s) begin
      win_addr_s = req1_addr;
      win_data_s = req1_data;
      win_id_s   = REQ_LD;
    end else begin
      win_addr_s = req0_addr;
      win_data_s = req0_data;
      win_id_s   = REQ_EXE;
    end
  end

  // Write-port register: one-cycle rf_load pulse, payload held between writes
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      rf_load_r  <= 1'b0;
      rf_addr_r  <= {ADDR_W{1'b0}};
      rf_data_r  <= {DATA_W{1'b0}};
      grant_id_r <= 1'b0;
    end else if (accept_s) begin
      rf_load_r  <= (win_addr_s != ADDR_W'(X0_IDX));
      rf_addr_r  <= win_addr_s;
      rf_data_r  <= win_data_s;
      grant_id_r <= win_id_s;
    end else begin
      rf_load_r  <= 1'b0;
    end
  end

  // Conflict counter, saturates at all-ones
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else if (both_s && (conflict_cnt_r != {CNT_W{1'b1}})) begin
      conflict_cnt_r <= conflict_cnt_r + CNT_W'(1);
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign rf_load      = rf_load_r;
  assign rf_addr      = rf_addr_r;
  assign rf_data      = rf_data_r;
  assign grant_id     = grant_id_r;
  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
// Scoreboard bench: the stimulus side predicts each accept from the arbitration
// rules and queues the expected write-port result; a monitor compares every
// cycle's write-port output against the queue head.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct {
    int          tag;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic        id;
  } exp_t;

  logic          clk;
  logic          res;
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          rf_load;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          grant_id;
  logic [CW-1:0] conflict_cnt;

  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   last_g = 1;
  int   model_cnt = 0;
  exp_t q[$];

  rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk          (clk),
    .res          (res),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_addr    (req0_addr),
    .req0_data    (req0_data),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_addr    (req1_addr),
    .req1_data    (req1_data),
    .rf_load      (rf_load),
    .rf_addr      (rf_addr),
    .rf_data      (rf_data),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: after each rising edge compare the write port against the queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      edge_n++;
      #1;
      if (res) begin
        checks++;
        if (q.size() > 0 && q[0].tag == edge_n) begin
          e = q.pop_front();
          if (rf_load !== 1'b1 || rf_addr !== e.addr || rf_data !== e.data || grant_id !== e.id) begin
            errors++;
            $display("FAIL write edge %0d: got load=%b addr=%0d data=%h id=%b, want load=1 addr=%0d data=%h id=%b",
                     edge_n, rf_load, rf_addr, rf_data, grant_id, e.addr, e.data, e.id);
          end
        end else if (rf_load !== 1'b0) begin
          errors++;
          $display("FAIL idle edge %0d: got rf_load=%b addr=%0d, want rf_load=0", edge_n, rf_load, rf_addr);
        end
      end
    end
  end

  // One stimulus cycle: drive at the falling edge, predict grant and result
  task automatic step(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      output int g);
    exp_t e;
    @(negedge clk);
    checks++;
    if (conflict_cnt !== CW'(model_cnt)) begin
      errors++;
      $display("FAIL conflict_cnt: got %0d, want %0d", conflict_cnt, model_cnt);
    end
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    g = -1;
    if (v0 && !v1) g = 0;
    else if (v1 && !v0) g = 1;
    else if (v0 && v1) begin
`ifdef RF_ARB_LOAD_PRIO_EN
      g = 1;
`else
      g = (last_g == 1) ? 0 : 1;
`endif
    end
    checks++;
    if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
      errors++;
      $display("FAIL ready: got r0=%b r1=%b, want r0=%b r1=%b", req0_ready, req1_ready, (g == 0), (g == 1));
    end
    if (g >= 0) begin
      last_g = g;
      e.tag  = edge_n + 1;
      e.addr = (g == 0) ? a0 : a1;
      e.data = (g == 0) ? d0 : d1;
      e.id   = (g == 1);
      if (e.addr != 0) q.push_back(e);
    end
    if (v0 && v1 && model_cnt < CNT_MAX) model_cnt++;
  endtask

  // Assert reset now (any phase), check immediate effect, release at a falling edge
  task automatic do_reset();
    res = 1'b0;
    #1;
    checks++;
    if (rf_load !== 1'b0 || rf_addr !== '0 || rf_data !== '0 || grant_id !== 1'b0 ||
        conflict_cnt !== '0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset state: got load=%b addr=%0d data=%h id=%b cnt=%0d r0=%b r1=%b, want all 0",
               rf_load, rf_addr, rf_data, grant_id, conflict_cnt, req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    q.delete();
    last_g = 1;
    model_cnt = 0;
    repeat (2) @(negedge clk);
    res = 1'b1;
  endtask

  initial begin
    int g;
    logic          p0, p1;
    logic [AW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;

    res = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    #2;
    do_reset();

    // Lone execute write, zero-wait
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, g);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);

    // Four-cycle conflict after reset: 0,1,0,1 then count of 4
    @(posedge clk); #2;
    do_reset();
    repeat (4) step(1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd7, 32'h0000_0777, g);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);

    // Load to x0 is consumed without a write
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_1234, g);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);

    // Reset mid-write cancels the pending load; first conflict goes to 0
    step(1'b1, 5'd9, 32'hCAFE_0009, 1'b0, 5'd0, 32'h0, g);
    @(posedge clk); #3;
    do_reset();
    step(1'b1, 5'd3, 32'hAAAA_0003, 1'b1, 5'd7, 32'hBBBB_0007, g);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hBBBB_0007, g);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);

    // Randomised traffic; requesters hold until accepted
    p0 = 1'b0; p1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 400; i++) begin
      if (!p0 && ($urandom_range(0, 2) != 0)) begin
        p0 = 1'b1; pa0 = AW'($urandom_range(0, 31)); pd0 = $urandom;
      end
      if (!p1 && ($urandom_range(0, 2) != 0)) begin
        p1 = 1'b1; pa1 = AW'($urandom_range(0, 31)); pd1 = $urandom;
      end
      step(p0, pa0, pd0, p1, pa1, pd1, g);
      if (g == 0) p0 = 1'b0;
      if (g == 1) p1 = 1'b0;
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);

    // Counter saturation
    @(posedge clk); #2;
    do_reset();
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      step(1'b1, 5'd3, 32'h1111_0003, 1'b1, 5'd7, 32'h2222_0007, g);
    end
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, g);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d writes still expected, want 0", q.size());
    end
    checks++;
    if (conflict_cnt !== CW'(CNT_MAX)) begin
      errors++;
      $display("FAIL saturation: got %0d, want %0d", conflict_cnt, CNT_MAX);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register index width (32 registers, x0 hardwired zero).
REQ-003 Parameter CNT_W, default 16, conflict counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 res  input  1  asynchronous, active-low reset.
REQ-006 req0_valid / req0_ready  input / output  1 / 1  execute-stage writeback handshake.
REQ-007 req0_addr / req0_data  input  ADDR_W / DATA_W  writeback destination register and value.
REQ-008 req1_valid / req1_ready  input / output  1 / 1  load-return writeback handshake.
REQ-009 req1_addr / req1_data  input  ADDR_W / DATA_W  load destination register and value.
REQ-010 rf_load  output  1  write enable to the register file write port.
REQ-011 rf_addr / rf_data  output  ADDR_W / DATA_W  write port address and data.
REQ-012 grant_id  output  1  requester that produced the current rf_load write.
REQ-013 conflict_cnt  output  CNT_W  saturating count of cycles with both requests valid.

Function
REQ-014 The block SHALL accept a request when valid and ready are both high at a rising edge; at most one accept per cycle.
REQ-015 req0_ready/req1_ready SHALL be combinational from valids and arbitration state; ready never high without its valid.
REQ-016 A lone valid requester SHALL be granted in the same cycle (zero-wait).
REQ-017 With both valid, the grant SHALL go to the requester not recorded in the 2-state pointer FSM (LAST0/LAST1).
REQ-018 The pointer SHALL move to LAST0/LAST1 on every accept by requester 0/1; it holds when nothing is accepted.
REQ-019 Accepted addr/data/id SHALL appear on rf_addr/rf_data/grant_id exactly one cycle after the accept, with rf_load high for one cycle.
REQ-020 An accept with addr 0 SHALL be consumed (ready high) but SHALL produce rf_load low the following cycle.
REQ-021 With no accept, rf_load SHALL be low the next cycle; rf_addr/rf_data/grant_id hold their last values.
REQ-022 Requesters SHALL hold valid, addr, data stable until accepted; the block does not buffer unaccepted requests.
REQ-023 conflict_cnt SHALL increment each cycle both valids are high and saturate at all-ones without wrapping.

Reset
REQ-024 While res is low: rf_load 0, rf_addr 0, rf_data 0, grant_id 0, conflict_cnt 0, pointer LAST1.
REQ-025 Reset SHALL take effect immediately, including mid-write (a pending rf_load is cancelled); readys SHALL be low during reset.
REQ-026 First conflict after reset SHALL be granted to requester 0.

Configuration
REQ-027 Macro RF_ARB_LOAD_PRIO_EN defined: requester 1 SHALL always win conflicts and the pointer FSM is not implemented.
REQ-028 Macro RF_ARB_LOAD_PRIO_EN undefined: round-robin per REQ-017/018; all other behaviour identical in both builds.

Structure
REQ-029 Shared package rv32_rf_pkg SHALL hold DATA_W, ADDR_W, the x0 index constant and the requester-id encoding (REQ_EXE=0, REQ_LD=1).
REQ-030 The grant decision SHALL live in sub-module rf_rr_pick (two valids and pointer in, one-hot grant out); the output register and counter stay in rf_wb_arbiter.

Verification
REQ-031 req0 valid, addr 5, data 0xDEADBEEF, req1 idle -> req0_ready same cycle; next cycle rf_load=1, rf_addr=5, rf_data=0xDEADBEEF, grant_id=0.
REQ-032 After reset, both valid (req0 addr 3, req1 addr 7) held 4 cycles -> grants 0,1,0,1; rf_addr 3,7,3,7; conflict_cnt=4.
REQ-033 req1 valid addr 0 data 0x1234 -> req1_ready=1; next cycle rf_load=0.
REQ-034 Both valid held 2^CNT_W+3 cycles -> conflict_cnt stops at 0xFFFF (CNT_W=16).
REQ-035 Accept req0 addr 9, drive res low before next edge -> rf_load 0 immediately; after release first conflict goes to requester 0.
REQ-036 RF_ARB_LOAD_PRIO_EN build, both valid 3 cycles -> grant_id 1,1,1; req0_ready stays low.
